// File: rtl/audio_avg_filter_if.sv
// Codec-side stereo sample handshake bundle for the moving-average filter.
interface audio_avg_filter_if #(
  parameter int unsigned DATA_W = 24
);
  logic              read_ready;
  logic [DATA_W-1:0] readdata_left;
  logic [DATA_W-1:0] readdata_right;
  logic              write_ready;
  logic              filter_en;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata_left;
  logic [DATA_W-1:0] writedata_right;
  logic              busy;

  // Codec / stimulus side
  modport master (
    output read_ready, readdata_left, readdata_right, write_ready, filter_en,
    input  read, write, writedata_left, writedata_right, busy
  );

  // Filter side
  modport slave (
    input  read_ready, readdata_left, readdata_right, write_ready, filter_en,
    output read, write, writedata_left, writedata_right, busy
  );
endinterface

// File: rtl/audio_avg_filter.sv
// Stereo moving-average filter between codec input and output FIFOs.
// One sample in flight: IDLE captures, UPDATE filters, WRITE hands off.
module audio_avg_filter #(
  parameter int unsigned DATA_W    = 24,
  parameter int unsigned LOG2_TAPS = 3
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  audio_avg_filter_if.slave   bus
);

  localparam int unsigned TAPS  = 1 << LOG2_TAPS;
  localparam int unsigned SUM_W = DATA_W + LOG2_TAPS;

  typedef enum logic [1:0] {IDLE, UPDATE, WRITE} state_t;

  state_t state_q, state_d;
  logic   read_q, read_d;
  logic   write_q, write_d;
  logic   busy_q, busy_d;
  logic   capture_c, update_c;

  logic                     fen_q;
  logic signed [DATA_W-1:0] lat_l_q, lat_r_q;
  logic signed [DATA_W-1:0] hist_l_q [TAPS];
  logic signed [DATA_W-1:0] hist_r_q [TAPS];
  logic signed [SUM_W-1:0]  sum_l_q, sum_r_q;
  logic [LOG2_TAPS-1:0]     ptr_q;
  logic [DATA_W-1:0]        wd_l_q, wd_r_q;

  logic signed [SUM_W-1:0]  sum_l_c, sum_r_c;
  logic [DATA_W-1:0]        avg_l_c, avg_r_c;

  // State register
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state and next-output decode
  always_comb begin
    state_d   = state_q;
    read_d    = 1'b0;
    write_d   = 1'b0;
    capture_c = 1'b0;
    update_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.read_ready) begin
          state_d   = UPDATE;
          read_d    = 1'b1;
          capture_c = 1'b1;
        end
      end
      UPDATE: begin
        state_d  = WRITE;
        update_c = 1'b1;
      end
      WRITE: begin
        if (bus.write_ready) begin
          state_d = IDLE;
          write_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // Handshake output registers
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      read_q  <= 1'b0;
      write_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      read_q  <= read_d;
      write_q <= write_d;
      busy_q  <= busy_d;
    end
  end

  // New window sums: add the incoming sample, drop the oldest one
  always_comb begin
    sum_l_c = sum_l_q + SUM_W'(lat_l_q) - SUM_W'(hist_l_q[ptr_q]);
    sum_r_c = sum_r_q + SUM_W'(lat_r_q) - SUM_W'(hist_r_q[ptr_q]);
    avg_l_c = DATA_W'(sum_l_c >>> LOG2_TAPS);
    avg_r_c = DATA_W'(sum_r_c >>> LOG2_TAPS);
  end

  // Sample capture, history/sum update and output data (history runs in bypass too)
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      fen_q   <= 1'b0;
      lat_l_q <= '0;
      lat_r_q <= '0;
      sum_l_q <= '0;
      sum_r_q <= '0;
      ptr_q   <= '0;
      wd_l_q  <= '0;
      wd_r_q  <= '0;
      for (int i = 0; i < int'(TAPS); i++) begin
        hist_l_q[i] <= '0;
        hist_r_q[i] <= '0;
      end
    end else begin
      if (capture_c) begin
        lat_l_q <= bus.readdata_left;
        lat_r_q <= bus.readdata_right;
        fen_q   <= bus.filter_en;
      end
      if (update_c) begin
        sum_l_q         <= sum_l_c;
        sum_r_q         <= sum_r_c;
        hist_l_q[ptr_q] <= lat_l_q;
        hist_r_q[ptr_q] <= lat_r_q;
        ptr_q           <= ptr_q + LOG2_TAPS'(1);
        wd_l_q          <= fen_q ? avg_l_c : lat_l_q;
        wd_r_q          <= fen_q ? avg_r_c : lat_r_q;
      end
    end
  end

  assign bus.read            = read_q;
  assign bus.write           = write_q;
  assign bus.busy            = busy_q;
  assign bus.writedata_left  = wd_l_q;
  assign bus.writedata_right = wd_r_q;

endmodule

// File: tb/tb_audio_avg_filter.sv
// Scoreboard bench for audio_avg_filter: a windowed-average reference model
// predicts each output sample; a monitor checks every write pulse.
module tb_audio_avg_filter;

  localparam int unsigned DW   = 24;
  localparam int unsigned L2   = 3;
  localparam int          TAPS = 8;

  typedef struct packed {
    logic [DW-1:0] l;
    logic [DW-1:0] r;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  audio_avg_filter_if #(.DATA_W(DW)) bus ();

  audio_avg_filter #(.DATA_W(DW), .LOG2_TAPS(L2)) dut (
    .CLOCK_50 (clk),
    .reset    (rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int            errors = 0;
  int            checks = 0;
  exp_t          exp_q[$];
  longint        hq_l[$];
  longint        hq_r[$];
  logic [DW-1:0] last_l = '0;
  logic [DW-1:0] last_r = '0;
  logic [DW-1:0] cur_l  = '0;
  logic [DW-1:0] cur_r  = '0;
  bit            cur_fen = 1'b0;
  int            rd_cnt = 0;
  int            wr_cnt = 0;
  bit            rd_prev = 1'b0;
  bit            wr_prev = 1'b0;
  bit            rand_wr = 1'b0;

  function automatic void chk(string nm, longint act, longint expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endfunction

  function automatic longint fdiv(longint s);
    if (s >= 0) return s / TAPS;
    return -((-s + TAPS - 1) / TAPS);
  endfunction

  function automatic void model_reset();
    hq_l.delete();
    hq_r.delete();
    for (int i = 0; i < TAPS; i++) begin
      hq_l.push_back(0);
      hq_r.push_back(0);
    end
    exp_q.delete();
  endfunction

  // Reference: average of the last TAPS samples (floor), or the raw sample in bypass
  function automatic void model_push(logic [DW-1:0] l, logic [DW-1:0] r, bit fen);
    longint sl = 0;
    longint sr = 0;
    exp_t   e;
    hq_l.push_back(longint'($signed(l)));
    hq_r.push_back(longint'($signed(r)));
    void'(hq_l.pop_front());
    void'(hq_r.pop_front());
    foreach (hq_l[i]) sl += hq_l[i];
    foreach (hq_r[i]) sr += hq_r[i];
    e.l = fen ? DW'(fdiv(sl)) : l;
    e.r = fen ? DW'(fdiv(sr)) : r;
    exp_q.push_back(e);
  endfunction

  task automatic drive(input logic [DW-1:0] l, input logic [DW-1:0] r, input bit fen);
    cur_l = l;
    cur_r = r;
    cur_fen = fen;
    bus.readdata_left  = l;
    bus.readdata_right = r;
    bus.filter_en      = fen;
    bus.read_ready     = 1'b1;
  endtask

  task automatic wait_read();
    bit got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (bus.read) begin
        got = 1'b1;
        model_push(cur_l, cur_r, cur_fen);
        bus.read_ready = 1'b0;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL read_timeout: no read pulse within 200 cycles");
    end
  endtask

  task automatic send(input logic [DW-1:0] l, input logic [DW-1:0] r, input bit fen);
    drive(l, r, fen);
    wait_read();
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d samples still pending, required 0", exp_q.size());
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("reset_read", longint'(bus.read), 0);
    chk("reset_write", longint'(bus.write), 0);
    chk("reset_busy", longint'(bus.busy), 0);
    chk("reset_wdata_left", longint'(bus.writedata_left), 0);
    chk("reset_wdata_right", longint'(bus.writedata_right), 0);
    bus.read_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.read_ready     = 1'b0;
    bus.readdata_left  = '0;
    bus.readdata_right = '0;
    bus.write_ready    = 1'b0;
    bus.filter_en      = 1'b0;
    model_reset();
    fork
      begin : stim
        logic [DW-1:0] snap_l, snap_r;
        int bad, rd0, wr0;
        @(negedge clk);
        do_reset();

        // Bypass passes samples through unchanged
        bus.write_ready = 1'b1;
        send(24'h123456, 24'hFEDCBA, 1'b0);
        drain();
        chk("bypass_left", longint'(last_l), longint'(24'h123456));
        chk("bypass_right", longint'(last_r), longint'(24'hFEDCBA));

        // Constant input ramps up, then step to zero ramps down across the wrap
        do_reset();
        for (int i = 0; i < 10; i++) send(DW'(800), DW'(i * 3), 1'b1);
        drain();
        chk("ramp_up_final", longint'($signed(last_l)), 800);
        for (int i = 0; i < 8; i++) send('0, '0, 1'b1);
        drain();
        chk("ramp_down_final", longint'($signed(last_l)), 0);

        // Floor rounding of negative averages
        do_reset();
        send(DW'(-8), DW'(-7), 1'b1);
        drain();
        chk("floor_minus8", longint'($signed(last_l)), -1);
        chk("floor_minus7", longint'($signed(last_r)), -1);
        do_reset();
        send(DW'(-1), DW'(7), 1'b1);
        drain();
        chk("floor_minus1", longint'($signed(last_l)), -1);
        chk("floor_plus7", longint'($signed(last_r)), 0);

        // Output back-pressure stall
        bus.write_ready = 1'b0;
        send(DW'($urandom), DW'($urandom), 1'b1);
        repeat (2) @(negedge clk);
        snap_l = bus.writedata_left;
        snap_r = bus.writedata_right;
        drive(DW'($urandom), DW'($urandom), 1'b0);
        rd0 = rd_cnt;
        bad = 0;
        repeat (50) begin
          @(negedge clk);
          if (!bus.busy || bus.read || bus.write ||
              bus.writedata_left != snap_l || bus.writedata_right != snap_r) bad++;
        end
        chk("stall_violations", bad, 0);
        chk("stall_reads", rd_cnt - rd0, 0);
        wr0 = wr_cnt;
        bus.write_ready = 1'b1;
        wait_read();
        chk("stall_release_writes", wr_cnt - wr0, 1);
        drain();

        // Reset in the middle of WRITE
        do_reset();
        for (int i = 0; i < 5; i++) send(DW'(800), DW'(800), 1'b1);
        drain();
        bus.write_ready = 1'b0;
        send(DW'(800), DW'(800), 1'b1);
        repeat (3) @(negedge clk);
        chk("midop_busy", longint'(bus.busy), 1);
        chk("midop_wdata_left", longint'($signed(bus.writedata_left)), 600);
        #2;
        do_reset();
        bus.write_ready = 1'b1;
        send(DW'(800), DW'(800), 1'b1);
        drain();
        chk("post_reset_first", longint'($signed(last_l)), 100);

        // Randomized samples, modes, gaps and output back-pressure
        rand_wr = 1'b1;
        for (int i = 0; i < 300; i++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          send(DW'($urandom), DW'($urandom), 1'($urandom_range(0, 1)));
        end
        rand_wr = 1'b0;
        bus.write_ready = 1'b1;
        drain();
        repeat (3) @(negedge clk);
      end
      begin : mon
        forever begin
          exp_t e;
          @(negedge clk);
          if (bus.read || bus.write) begin
            checks++;
            if ((bus.read && bus.write) || (bus.read && rd_prev) || (bus.write && wr_prev)) begin
              errors++;
              $display("FAIL pulse_protocol: read=%0b write=%0b prev_read=%0b prev_write=%0b, required single non-overlapping pulses",
                       bus.read, bus.write, rd_prev, wr_prev);
            end
          end
          if (bus.read) rd_cnt++;
          if (bus.write) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_write: write pulse with no pending sample");
            end else begin
              e = exp_q.pop_front();
              chk("wdata_left", longint'($signed(bus.writedata_left)), longint'($signed(e.l)));
              chk("wdata_right", longint'($signed(bus.writedata_right)), longint'($signed(e.r)));
              last_l = bus.writedata_left;
              last_r = bus.writedata_right;
            end
          end
          rd_prev = bus.read;
          wr_prev = bus.write;
        end
      end
      begin : wrdrv
        forever begin
          @(negedge clk);
          if (rand_wr) bus.write_ready = 1'($urandom_range(0, 1));
        end
      end
    join_any
    disable fork;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/audio_avg_filter.md
AUDIO_AVG_FILTER -- requirements
Module: audio_avg_filter

Interface
- REQ-001: Parameter DATA_W, default 24, is the sample width per channel in bits, two's complement.
- REQ-002: Parameter LOG2_TAPS, default 3, is log2 of the moving-average length per channel (TAPS = 2^LOG2_TAPS).
- REQ-003: Port CLOCK_50  input  1  is the single clock; all state changes on its rising edge.
- REQ-004: Port reset  input  1  is the reset, asynchronous and active-high.
- REQ-005: Port read_ready  input  1  is high when the codec has a stereo input sample available.
- REQ-006: Port readdata_left  input  DATA_W  is the codec left input sample.
- REQ-007: Port readdata_right  input  DATA_W  is the codec right input sample.
- REQ-008: Port write_ready  input  1  is high when the codec can accept a stereo output sample.
- REQ-009: Port filter_en  input  1  selects averaged output (1) or bypass (0).
- REQ-010: Port read  output  1  is a one-cycle pulse that consumes the codec input sample.
- REQ-011: Port write  output  1  is a one-cycle pulse that pushes writedata_left/right to the codec.
- REQ-012: Port writedata_left  output  DATA_W  is the left output sample.
- REQ-013: Port writedata_right  output  DATA_W  is the right output sample.
- REQ-014: Port busy  output  1  is high whenever the FSM is not in IDLE.

Function
- REQ-015: The FSM SHALL have exactly three states: IDLE, UPDATE and WRITE; read, write, writedata_* and busy SHALL all be registered.
- REQ-016: In IDLE, a rising edge with read_ready=1 SHALL latch both readdata channels and filter_en, drive read=1 for the next cycle only, and enter UPDATE; with read_ready=0 the FSM SHALL stay in IDLE.
- REQ-017: In UPDATE, for each channel:
  - sum <= sum + new - hist[ptr]
  - hist[ptr] <= new
  - ptr <= ptr+1, wrapping from TAPS-1 to 0
  - writedata_* <= latched filter_en ? (sum + new - hist[ptr]) >>> LOG2_TAPS : new
  - next state is WRITE, unconditionally.
- REQ-018: Each per-channel sum SHALL be signed, DATA_W+LOG2_TAPS bits wide, and SHALL never overflow.
- REQ-019: The shift SHALL be arithmetic, with the result truncated to DATA_W bits (floor rounding toward minus infinity).
- REQ-020: History buffer and sum SHALL update identically in bypass mode, so that switching modes is seamless.
- REQ-021: In WRITE, a rising edge with write_ready=1 SHALL drive write=1 for the next cycle only and return to IDLE; with write_ready=0 the FSM SHALL hold in WRITE indefinitely without asserting read.
- REQ-022: writedata_* SHALL stay stable from the UPDATE edge until the next UPDATE edge.
- REQ-023: read and write SHALL never be high in the same cycle, and each SHALL be high for at most one consecutive cycle.
- REQ-024: Minimum loop latency SHALL be: read pulse one cycle after read_ready is sampled, writedata valid one cycle later, write pulse one cycle after write_ready is sampled in WRITE; at most one sample is in flight.
- REQ-025: Left and right channels SHALL share the FSM and pointer and be processed in the same cycles.
- REQ-026: A filter_en change SHALL take effect only at the next IDLE-to-UPDATE capture.

Reset
- REQ-027: Asserting reset at any time, including mid-operation, SHALL immediately force: state IDLE, read=0, write=0, busy=0, writedata_*=0, all hist entries=0, sums=0, ptr=0.
- REQ-028: After reset deasserts, the first sample SHALL be processed as though preceded by TAPS zero samples.

Verification
- REQ-029: Reset then filter_en=0, left=0x123456, right=0xFEDCBA, write_ready=1 -> read pulse, then write pulse with writedata_left=0x123456 and writedata_right=0xFEDCBA.
- REQ-030: LOG2_TAPS=3, filter_en=1, left constant 800 for 10 samples -> writedata_left = 100,200,...,800,800,800.
- REQ-031: Continue with left=0 after 8 samples of 800 -> outputs 700,600,...,0, confirming ptr wrap.
- REQ-032: filter_en=1, first sample after reset left=-8 -> output -1; left=-1 -> output -1 (floor).
- REQ-033: Hold write_ready=0 for 50 cycles while read_ready=1 -> FSM stays in WRITE, busy=1, no read pulse, writedata stable; release -> exactly one write, then the next read.
- REQ-034: Assert reset during WRITE after 5 samples of 800 -> all outputs 0 at once; next sample 800 with filter on -> output 100.
